// File: rtl/minhash_topk_sorter_pkg.sv
// Shared types and default widths for the MinHash bottom-K sorter and its neighbours.
package minhash_topk_sorter_pkg;

  localparam int SORTER_EXTENDER_INDICES_COUNT = 4;
  localparam int HASHER_SORTER_SIGNATURE       = 32;
  localparam int INDICE_LEN                    = 5;

  typedef struct packed {
    logic [HASHER_SORTER_SIGNATURE-1:0] signature;
    logic [INDICE_LEN-1:0]              index;
  } signature_index_pack;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } topk_state_e;

endpackage

// File: rtl/minhash_topk_slot.sv
// One cell of the sorted register array: decides whether the new pair lands here,
// whether the predecessor shifts down into it, or whether it holds (purely combinational).
module minhash_topk_slot #(
  parameter int SIG_W = 32,
  parameter int IDX_W = 5
) (
  input  logic [SIG_W-1:0] i_sig,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_vld,
  input  logic [SIG_W-1:0] i_prev_sig,
  input  logic [IDX_W-1:0] i_prev_idx,
  input  logic             i_prev_vld,
  input  logic             i_prev_before,
  input  logic [SIG_W-1:0] i_new_sig,
  input  logic [IDX_W-1:0] i_new_idx,
  input  logic             i_ins,
  output logic             o_before,
  output logic [SIG_W-1:0] o_nxt_sig,
  output logic [IDX_W-1:0] o_nxt_idx,
  output logic             o_nxt_vld
);

  // Strict less-than keeps an equal, earlier pair ahead of the new one.
  assign o_before = !i_vld || (i_new_sig < i_sig);

  always_comb begin
    o_nxt_sig = i_sig;
    o_nxt_idx = i_idx;
    o_nxt_vld = i_vld;
    if (i_ins) begin
      if (i_prev_before) begin
        o_nxt_sig = i_prev_sig;
        o_nxt_idx = i_prev_idx;
        o_nxt_vld = i_prev_vld;
      end else if (o_before) begin
        o_nxt_sig = i_new_sig;
        o_nxt_idx = i_new_idx;
        o_nxt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/minhash_topk_sorter.sv
// Streaming bottom-K selector: keeps the TOPK smallest signatures, drains them ascending.
// First output 1 cycle after the in_last handshake; output holds under backpressure. Optional: MINHASH_TOPK_DEDUP_EN.
module minhash_topk_sorter
  import minhash_topk_sorter_pkg::*;
#(
  parameter int SIG_W = HASHER_SORTER_SIGNATURE,
  parameter int IDX_W = INDICE_LEN,
  parameter int TOPK  = SORTER_EXTENDER_INDICES_COUNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIG_W-1:0] in_signature,
  input  logic [IDX_W-1:0] in_index,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIG_W-1:0] out_signature,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last
);

  localparam int CW = $clog2(TOPK + 1);

  topk_state_e      r_state;
  logic [SIG_W-1:0] r_sig [TOPK];
  logic [IDX_W-1:0] r_idx [TOPK];
  logic             r_vld [TOPK];
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_rd_ptr;
  logic             r_in_rdy;
  logic             r_out_vld;
  logic             r_out_last;
  logic [SIG_W-1:0] r_out_sig;
  logic [IDX_W-1:0] r_out_idx;

  logic [SIG_W-1:0] w_nxt_sig [TOPK];
  logic [IDX_W-1:0] w_nxt_idx [TOPK];
  logic             w_nxt_vld [TOPK];
  logic             w_before  [TOPK];
  logic [SIG_W-1:0] w_prev_sig [TOPK];
  logic [IDX_W-1:0] w_prev_idx [TOPK];
  logic             w_prev_vld [TOPK];
  logic             w_prev_before [TOPK];
  logic             w_hs_in, w_hs_out, w_ins, w_dup;
  logic [CW-1:0]    w_count_nxt;
  logic [CW-1:0]    w_rd_nxt;
  logic [SIG_W-1:0] w_rd_sig;
  logic [IDX_W-1:0] w_rd_idx;

  assign w_hs_in  = in_valid & r_in_rdy;
  assign w_hs_out = r_out_vld & out_ready;
  assign w_ins    = w_hs_in & ~w_dup;

`ifdef MINHASH_TOPK_DEDUP_EN
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < TOPK; i++)
      if (r_vld[i] && (r_sig[i] == in_signature)) w_dup = 1'b1;
  end
`else
  assign w_dup = 1'b0;
`endif

  for (genvar i = 0; i < TOPK; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign w_prev_sig[i]    = '0;
      assign w_prev_idx[i]    = '0;
      assign w_prev_vld[i]    = 1'b0;
      assign w_prev_before[i] = 1'b0;
    end else begin : g_chain
      assign w_prev_sig[i]    = r_sig[i-1];
      assign w_prev_idx[i]    = r_idx[i-1];
      assign w_prev_vld[i]    = r_vld[i-1];
      assign w_prev_before[i] = w_before[i-1];
    end
    minhash_topk_slot #(.SIG_W(SIG_W), .IDX_W(IDX_W)) u_slot (
      .i_sig         (r_sig[i]),
      .i_idx         (r_idx[i]),
      .i_vld         (r_vld[i]),
      .i_prev_sig    (w_prev_sig[i]),
      .i_prev_idx    (w_prev_idx[i]),
      .i_prev_vld    (w_prev_vld[i]),
      .i_prev_before (w_prev_before[i]),
      .i_new_sig     (in_signature),
      .i_new_idx     (in_index),
      .i_ins         (w_ins),
      .o_before      (w_before[i]),
      .o_nxt_sig     (w_nxt_sig[i]),
      .o_nxt_idx     (w_nxt_idx[i]),
      .o_nxt_vld     (w_nxt_vld[i])
    );
  end

  // The tail slot's flag is set exactly when the new pair lands somewhere in the array.
  assign w_count_nxt = (w_ins && w_before[TOPK-1] && (r_count != CW'(TOPK)))
                       ? r_count + CW'(1) : r_count;
  assign w_rd_nxt    = r_rd_ptr + CW'(1);

  always_comb begin
    w_rd_sig = '0;
    w_rd_idx = '0;
    for (int i = 0; i < TOPK; i++)
      if (CW'(i) == w_rd_nxt) begin
        w_rd_sig = r_sig[i];
        w_rd_idx = r_idx[i];
      end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= COLLECT;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_in_rdy   <= 1'b1;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_out_sig  <= '0;
      r_out_idx  <= '0;
      for (int i = 0; i < TOPK; i++) begin
        r_vld[i] <= 1'b0;
        r_sig[i] <= '0;
        r_idx[i] <= '0;
      end
    end else begin
      case (r_state)
        COLLECT: begin
          for (int i = 0; i < TOPK; i++) begin
            r_sig[i] <= w_nxt_sig[i];
            r_idx[i] <= w_nxt_idx[i];
            r_vld[i] <= w_nxt_vld[i];
          end
          r_count <= w_count_nxt;
          if (w_hs_in && in_last) begin
            r_state    <= DRAIN;
            r_rd_ptr   <= '0;
            r_in_rdy   <= 1'b0;
            r_out_vld  <= 1'b1;
            r_out_sig  <= w_nxt_sig[0];
            r_out_idx  <= w_nxt_idx[0];
            r_out_last <= (w_count_nxt == CW'(1));
          end
        end
        DRAIN: begin
          if (w_hs_out) begin
            if (r_out_last) begin
              r_state    <= COLLECT;
              r_count    <= '0;
              r_in_rdy   <= 1'b1;
              r_out_vld  <= 1'b0;
              r_out_last <= 1'b0;
              r_out_sig  <= '0;
              r_out_idx  <= '0;
              for (int i = 0; i < TOPK; i++) r_vld[i] <= 1'b0;
            end else begin
              r_rd_ptr   <= w_rd_nxt;
              r_out_sig  <= w_rd_sig;
              r_out_idx  <= w_rd_idx;
              r_out_last <= (w_rd_nxt == r_count - CW'(1));
            end
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign in_ready      = r_in_rdy;
  assign out_valid     = r_out_vld;
  assign out_signature = r_out_sig;
  assign out_index     = r_out_idx;
  assign out_last      = r_out_last;

endmodule

// File: tb/tb_minhash_topk_sorter.sv
// Bench for minhash_topk_sorter: directed and random fragments against a stable-sort reference model.
module tb_minhash_topk_sorter;
  import minhash_topk_sorter_pkg::*;

  localparam int SIG_W = HASHER_SORTER_SIGNATURE;
  localparam int IDX_W = INDICE_LEN;
  localparam int TOPK  = SORTER_EXTENDER_INDICES_COUNT;
`ifdef MINHASH_TOPK_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [SIG_W-1:0] in_signature;
  logic [IDX_W-1:0] in_index;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [SIG_W-1:0] out_signature;
  logic [IDX_W-1:0] out_index;
  logic             out_last;

  minhash_topk_sorter dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_signature  (in_signature),
    .in_index      (in_index),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_signature (out_signature),
    .out_index     (out_index),
    .out_last      (out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  signature_index_pack tx_q[$];
  bit                  tx_last_q[$];
  signature_index_pack exp_q[$];
  bit                  exp_last_q[$];
  int unsigned         sigs_q[$];
  int                  stall_at   = -1;
  int                  stall_left = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: kept set = first TOPK of a stable ascending sort of the fragment
  // (with dedup, later repeats of a signature are discarded first).
  task automatic add_frag();
    signature_index_pack kept[$];
    int unsigned seen[$];
    int n = sigs_q.size();
    for (int i = 0; i < n; i++) begin
      signature_index_pack p;
      bit dup = 1'b0;
      int pos;
      p.signature = sigs_q[i];
      p.index     = IDX_W'(i);
      tx_q.push_back(p);
      tx_last_q.push_back(i == n - 1);
      foreach (seen[j]) if (seen[j] == sigs_q[i]) dup = 1'b1;
      seen.push_back(sigs_q[i]);
      if (DEDUP && dup) continue;
      pos = kept.size();
      for (int j = kept.size() - 1; j >= 0; j--)
        if (kept[j].signature > p.signature) pos = j;
      kept.insert(pos, p);
    end
    while (kept.size() > TOPK) void'(kept.pop_back());
    foreach (kept[j]) begin
      exp_q.push_back(kept[j]);
      exp_last_q.push_back(j == kept.size() - 1);
    end
  endtask

  task automatic sender();
    while (tx_q.size() > 0) begin
      int guard = 0;
      bit last;
      @(negedge clk);
      in_valid     = 1'b1;
      in_signature = tx_q[0].signature;
      in_index     = tx_q[0].index;
      in_last      = tx_last_q[0];
      while (!in_ready && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        check("sender_timeout", 0, 1);
        tx_q.delete();
        tx_last_q.delete();
        break;
      end
      @(posedge clk);
      last = tx_last_q[0];
      void'(tx_q.pop_front());
      void'(tx_last_q.pop_front());
      if (last) begin
        @(negedge clk);
        check("first_out_latency", 64'(out_valid), 1);
        check("in_ready_after_last", 64'(in_ready), 0);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic receiver();
    int guard = 0;
    int out_n = 0;
    bit held = 1'b0;
    logic [SIG_W-1:0] h_sig;
    logic [IDX_W-1:0] h_idx;
    while (exp_q.size() > 0 && guard < 3000) begin
      bit r;
      @(negedge clk);
      guard++;
      if (out_valid) begin
        check("in_ready_low_in_drain", 64'(in_ready), 0);
        if (held) begin
          check("hold_sig", 64'(out_signature), 64'(h_sig));
          check("hold_idx", 64'(out_index), 64'(h_idx));
        end else begin
          check("out_sig", 64'(out_signature), 64'(exp_q[0].signature));
          check("out_idx", 64'(out_index), 64'(exp_q[0].index));
          check("out_last", 64'(out_last), 64'(exp_last_q[0]));
        end
        if (stall_at == out_n && stall_left > 0) begin
          r = 1'b0;
          stall_left--;
        end else if (stall_at >= 0) begin
          r = 1'b1;
        end else begin
          r = ($urandom_range(0, 3) != 0);
        end
        out_ready = r;
        held  = !r;
        h_sig = out_signature;
        h_idx = out_index;
        if (r) begin
          out_n = exp_last_q[0] ? 0 : out_n + 1;
          void'(exp_q.pop_front());
          void'(exp_last_q.pop_front());
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    if (exp_q.size() > 0) begin
      check("receiver_timeout", 0, 1);
      exp_q.delete();
      exp_last_q.delete();
    end
  endtask

  task automatic run();
    fork
      sender();
      receiver();
    join
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_in_ready", 64'(in_ready), 1);
    check("idle_out_valid", 64'(out_valid), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_signature = '0; in_index = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_last", 64'(out_last), 0);
    check("rst_out_sig", 64'(out_signature), 0);
    check("rst_out_idx", 64'(out_index), 0);
    rst = 1'b0;

    // Basic eviction, short fragment, ties.
    sigs_q = '{50, 10, 40, 30, 20}; add_frag(); run();
    sigs_q = '{7, 3};               add_frag(); run();
    sigs_q = '{5, 5, 9};            add_frag(); run();

    // Backpressure: hold the 2nd output for 3 cycles.
    stall_at = 1; stall_left = 3;
    sigs_q = '{12, 4, 99, 4, 1, 60}; add_frag(); run();
    stall_at = -1;

    // Reset mid-drain after one output.
    sigs_q = '{50, 10, 40, 30, 20}; add_frag();
    sender();
    @(negedge clk);
    check("pre_rst_sig", 64'(out_signature), 64'(exp_q[0].signature));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_out_valid", 64'(out_valid), 0);
    check("mid_rst_in_ready", 64'(in_ready), 1);
    exp_q.delete();
    exp_last_q.delete();
    sigs_q = '{8}; add_frag(); run();

    // Back-to-back fragments, in_valid held high between them.
    sigs_q = '{3, 1, 2, 0, 9, 8}; add_frag();
    sigs_q = '{6, 6};             add_frag();
    run();

    // Randomized fragments, small value range to provoke ties.
    for (int f = 0; f < 12; f++) begin
      int n = $urandom_range(1, 9);
      sigs_q.delete();
      for (int i = 0; i < n; i++)
        sigs_q.push_back((f % 3 == 0) ? $urandom : $urandom_range(0, 12));
      add_frag();
      if (f % 2 == 1) run();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
